// File: rtl/si5345_cfg_sequencer_if.sv
// SPI master handshake/bus bundle between the Si5345 configuration
// sequencer (master side, issues frames) and the 4-wire SPI engine (slave side).
interface si5345_cfg_sequencer_if;
  logic        spi_start_o;
  logic        spi_rw_o;
  logic        spi_mlb_o;
  logic [15:0] spi_dout_o;
  logic        spi_busy_i;
  logic        spi_done_i;

  modport master (
    output spi_start_o,
    output spi_rw_o,
    output spi_mlb_o,
    output spi_dout_o,
    input  spi_busy_i,
    input  spi_done_i
  );

  modport slave (
    input  spi_start_o,
    input  spi_rw_o,
    input  spi_mlb_o,
    input  spi_dout_o,
    output spi_busy_i,
    output spi_done_i
  );
endinterface

// File: rtl/si5345_cfg_sequencer.sv
// Si5345 configuration sequencer: walks a {page, reg, data} register table
// in a synchronous ROM and turns every entry into 16-bit SPI write frames.
// A page-register write is inserted whenever the page changes, and a fixed
// settle delay follows the last preamble entry.
module si5345_cfg_sequencer #(
  parameter int          ADDR_WIDTH   = 10,
  parameter int          DELAY_INDEX  = 2,
  parameter int unsigned DELAY_CYCLES = 30000000
) (
  input  logic                  sys_clk,
  input  logic                  reset,
  input  logic                  cfg_start_i,
  input  logic [ADDR_WIDTH-1:0] reg_count_i,
  output logic                  cfg_busy_o,
  output logic                  cfg_done_o,
  output logic [ADDR_WIDTH-1:0] cur_index_o,
  output logic [ADDR_WIDTH-1:0] rom_addr_o,
  input  logic [23:0]           rom_data_i,
  si5345_cfg_sequencer_if.master spi
);

  localparam int DLY_W = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;
  localparam logic [DLY_W-1:0] DLY_LAST =
    (DELAY_CYCLES > 0) ? DLY_W'(DELAY_CYCLES - 1) : '0;
  localparam logic DELAY_EN = (DELAY_CYCLES != 0);
  localparam logic [ADDR_WIDTH-1:0] DLY_IDX = ADDR_WIDTH'(DELAY_INDEX);

  // Si5345 SPI command bytes and the page register address
  localparam logic [7:0] CMD_SET_ADDR = 8'h00;
  localparam logic [7:0] CMD_WRITE    = 8'h40;
  localparam logic [7:0] PAGE_REG     = 8'h01;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LATCH, S_XFER_REQ, S_XFER_WAIT, S_DELAY, S_NEXT, S_DONE
  } state_t;

  typedef enum logic [1:0] {
    F_P_ADDR, F_P_DATA, F_R_ADDR, F_R_DATA
  } frame_t;

  state_t                  state, state_n;
  frame_t                  frame, frame_n;
  logic [ADDR_WIDTH-1:0]   index, index_n;
  logic [ADDR_WIDTH-1:0]   count, count_n;
  logic [7:0]              pg, pg_n;
  logic [7:0]              rg, rg_n;
  logic [7:0]              dt, dt_n;
  logic [7:0]              cur_page, cur_page_n;
  logic                    page_valid, page_valid_n;
  logic [DLY_W-1:0]        dly_cnt, dly_cnt_n;
  logic                    busy, busy_n;
  logic                    done, done_n;
  logic [15:0]             dout, dout_n;

  // Frame word for a given position in the per-entry frame queue
  function automatic logic [15:0] frame_word(input frame_t f, input logic [7:0] p,
                                             input logic [7:0] r, input logic [7:0] d);
    logic [15:0] w;
    case (f)
      F_P_ADDR: w = {CMD_SET_ADDR, PAGE_REG};
      F_P_DATA: w = {CMD_WRITE, p};
      F_R_ADDR: w = {CMD_SET_ADDR, r};
      default:  w = {CMD_WRITE, d};
    endcase
    return w;
  endfunction

  // Next-state and registered-output logic for the table walker
  always_comb begin
    state_n      = state;
    frame_n      = frame;
    index_n      = index;
    count_n      = count;
    pg_n         = pg;
    rg_n         = rg;
    dt_n         = dt;
    cur_page_n   = cur_page;
    page_valid_n = page_valid;
    dly_cnt_n    = dly_cnt;
    busy_n       = busy;
    done_n       = 1'b0;
    dout_n       = dout;

    case (state)
      S_IDLE: begin
        if (cfg_start_i) begin
          if (reg_count_i != '0) begin
            count_n      = reg_count_i;
            index_n      = '0;
            page_valid_n = 1'b0;
            busy_n       = 1'b1;
            state_n      = S_FETCH;
          end else begin
            done_n = 1'b1;
          end
        end
      end

      // rom_addr_o already carries index; the ROM answers next cycle
      S_FETCH: state_n = S_LATCH;

      S_LATCH: begin
        pg_n = rom_data_i[23:16];
        rg_n = rom_data_i[15:8];
        dt_n = rom_data_i[7:0];
        if (!page_valid || (rom_data_i[23:16] != cur_page)) begin
          frame_n = F_P_ADDR;
        end else begin
          frame_n = F_R_ADDR;
        end
        dout_n  = frame_word(frame_n, rom_data_i[23:16], rom_data_i[15:8], rom_data_i[7:0]);
        state_n = S_XFER_REQ;
      end

      // Start is held until the master reports busy, so it is low again
      // well before the master can return to idle
      S_XFER_REQ: begin
        if (spi.spi_busy_i) begin
          state_n = S_XFER_WAIT;
        end
      end

      S_XFER_WAIT: begin
        if (spi.spi_done_i) begin
          if (frame == F_R_DATA) begin
            if (DELAY_EN && (index == DLY_IDX)) begin
              state_n = S_DELAY;
            end else begin
              state_n = S_NEXT;
            end
          end else begin
            if (frame == F_P_DATA) begin
              cur_page_n   = pg;
              page_valid_n = 1'b1;
            end
            frame_n = frame_t'(frame + 2'd1);
            dout_n  = frame_word(frame_n, pg, rg, dt);
            state_n = S_XFER_REQ;
          end
        end
      end

      S_DELAY: begin
        if (dly_cnt == DLY_LAST) begin
          dly_cnt_n = '0;
          state_n   = S_NEXT;
        end else begin
          dly_cnt_n = dly_cnt + DLY_W'(1);
        end
      end

      S_NEXT: begin
        if (index == (count - ADDR_WIDTH'(1))) begin
          done_n  = 1'b1;
          busy_n  = 1'b0;
          state_n = S_DONE;
        end else begin
          index_n = index + ADDR_WIDTH'(1);
          state_n = S_FETCH;
        end
      end

      S_DONE: state_n = S_IDLE;

      default: state_n = S_IDLE;
    endcase
  end

  // Control state register with synchronous reset; aborts any load in flight
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state      <= S_IDLE;
      frame      <= F_P_ADDR;
      index      <= '0;
      page_valid <= 1'b0;
      dly_cnt    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      dout       <= 16'h0000;
    end else begin
      state      <= state_n;
      frame      <= frame_n;
      index      <= index_n;
      page_valid <= page_valid_n;
      dly_cnt    <= dly_cnt_n;
      busy       <= busy_n;
      done       <= done_n;
      dout       <= dout_n;
    end
  end

  // Entry fields and table length; only meaningful while a load is active
  always_ff @(posedge sys_clk) begin
    count    <= count_n;
    pg       <= pg_n;
    rg       <= rg_n;
    dt       <= dt_n;
    cur_page <= cur_page_n;
  end

  assign cfg_busy_o      = busy;
  assign cfg_done_o      = done;
  assign cur_index_o     = index;
  assign rom_addr_o      = index;
  assign spi.spi_start_o = (state == S_XFER_REQ);
  assign spi.spi_rw_o    = 1'b0;
  assign spi.spi_mlb_o   = 1'b1;
  assign spi.spi_dout_o  = dout;

endmodule

// File: tb/tb_si5345_cfg_sequencer.sv
// Randomized bench for si5345_cfg_sequencer: a synchronous ROM model, an SPI
// master model with random busy latency, and a table-level reference model
// that derives the expected frame stream from the register table.
module tb_si5345_cfg_sequencer;
  localparam int AW = 4;
  localparam int DI = 1;
  localparam int DC = 50;

  logic          sys_clk = 1'b0;
  logic          reset = 1'b1;
  logic          cfg_start_i = 1'b0;
  logic [AW-1:0] reg_count_i = '0;
  logic          cfg_busy_o;
  logic          cfg_done_o;
  logic [AW-1:0] cur_index_o;
  logic [AW-1:0] rom_addr_o;
  logic [23:0]   rom_data_i = '0;

  si5345_cfg_sequencer_if spi_if();

  si5345_cfg_sequencer #(
    .ADDR_WIDTH  (AW),
    .DELAY_INDEX (DI),
    .DELAY_CYCLES(DC)
  ) dut (
    .sys_clk    (sys_clk),
    .reset      (reset),
    .cfg_start_i(cfg_start_i),
    .reg_count_i(reg_count_i),
    .cfg_busy_o (cfg_busy_o),
    .cfg_done_o (cfg_done_o),
    .cur_index_o(cur_index_o),
    .rom_addr_o (rom_addr_o),
    .rom_data_i (rom_data_i),
    .spi        (spi_if.master)
  );

  always #5 sys_clk = ~sys_clk;

  // Synchronous ROM: data one cycle after the address
  logic [23:0] rom [16];
  always @(posedge sys_clk) rom_data_i <= rom[rom_addr_o];

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_miss = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // SPI master model: captures a frame on start, raises busy after a random
  // latency, holds busy a random time, then pulses done
  int          phase = 0;
  int          mcnt = 0;
  logic [15:0] cap = '0;
  logic [15:0] got_q[$];
  int          got_idx[$];
  int          t_start[$];
  int          t_done[$];
  int          dout_err = 0;
  int          dup_err = 0;

  initial begin
    spi_if.spi_busy_i = 1'b0;
    spi_if.spi_done_i = 1'b0;
  end

  always @(negedge sys_clk) begin
    spi_if.spi_done_i = 1'b0;
    case (phase)
      0: if (spi_if.spi_start_o) begin
        cap = spi_if.spi_dout_o;
        got_q.push_back(cap);
        got_idx.push_back(int'(cur_index_o));
        t_start.push_back(cyc);
        mcnt  = $urandom_range(1, 4);
        phase = 1;
      end
      1: begin
        if (spi_if.spi_dout_o !== cap) dout_err++;
        mcnt--;
        if (mcnt == 0) begin
          spi_if.spi_busy_i = 1'b1;
          mcnt  = $urandom_range(2, 5);
          phase = 2;
        end
      end
      default: begin
        if (spi_if.spi_dout_o !== cap) dout_err++;
        if (spi_if.spi_start_o) dup_err++;
        mcnt--;
        if (mcnt == 0) begin
          spi_if.spi_busy_i = 1'b0;
          spi_if.spi_done_i = 1'b1;
          t_done.push_back(cyc);
          phase = 0;
        end
      end
    endcase
  end

  // Reference model: expected frame stream for the first n table entries
  logic [15:0] exp_q[$];
  int          exp_idx[$];
  int          last_f[16];

  function automatic void build_exp(input int n);
    bit       pv = 1'b0;
    bit [7:0] cp = 8'h00;
    bit [7:0] p, r, d;
    exp_q.delete();
    exp_idx.delete();
    for (int e = 0; e < n; e++) begin
      {p, r, d} = rom[e];
      if (!pv || p != cp) begin
        exp_q.push_back(16'h0001);         exp_idx.push_back(e);
        exp_q.push_back({8'h40, p});       exp_idx.push_back(e);
        cp = p;
        pv = 1'b1;
      end
      exp_q.push_back({8'h00, r});         exp_idx.push_back(e);
      exp_q.push_back({8'h40, d});         exp_idx.push_back(e);
      last_f[e] = exp_q.size() - 1;
    end
  endfunction

  task automatic wait_idle(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (phase == 0 && !spi_if.spi_busy_i) begin
        ok = 1'b1;
        break;
      end
      @(negedge sys_clk);
    end
    chk({name, " spi_idle"}, 32'(ok), 32'd1);
  endtask

  task automatic clear_mon();
    got_q.delete();
    got_idx.delete();
    t_start.delete();
    t_done.delete();
    dout_err = 0;
    dup_err  = 0;
  endtask

  task automatic run_load(input int n, input string name);
    bit seen = 1'b0;
    int ndone = 0;
    int base, gap;
    build_exp(n);
    wait_idle(name);
    repeat (2) @(negedge sys_clk);
    clear_mon();
    cfg_start_i = 1'b1;
    reg_count_i = AW'(n);
    @(negedge sys_clk);
    cfg_start_i = 1'b0;
    if (n == 0) begin
      chk({name, " zero_done"}, 32'(cfg_done_o), 32'd1);
      chk({name, " zero_busy"}, 32'(cfg_busy_o), 32'd0);
      @(negedge sys_clk);
      chk({name, " zero_done_width"}, 32'(cfg_done_o), 32'd0);
      repeat (20) @(negedge sys_clk);
      chk({name, " zero_frames"}, 32'(got_q.size()), 32'd0);
      return;
    end
    chk({name, " busy_after_start"}, 32'(cfg_busy_o), 32'd1);
    // a start while busy must be ignored
    repeat (5) @(negedge sys_clk);
    cfg_start_i = 1'b1;
    reg_count_i = AW'(n + 3);
    @(negedge sys_clk);
    cfg_start_i = 1'b0;
    for (int i = 0; i < 4000 && !seen; i++) begin
      @(negedge sys_clk);
      if (cfg_done_o) begin
        seen = 1'b1;
        ndone++;
      end
    end
    chk({name, " done_seen"}, 32'(seen), 32'd1);
    chk({name, " busy_at_done"}, 32'(cfg_busy_o), 32'd0);
    repeat (4) begin
      @(negedge sys_clk);
      if (cfg_done_o) ndone++;
    end
    chk({name, " done_pulses"}, 32'(ndone), 32'd1);
    chk({name, " busy_after"}, 32'(cfg_busy_o), 32'd0);
    chk({name, " frame_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      chk($sformatf("%s frame%0d", name, i), 32'(got_q[i]), 32'(exp_q[i]));
      chk($sformatf("%s index%0d", name, i), 32'(got_idx[i]), 32'(exp_idx[i]));
    end
    chk({name, " dout_stable"}, 32'(dout_err), 32'd0);
    chk({name, " start_dropped"}, 32'(dup_err), 32'd0);
    // settle delay shows up as extra gap after entry DI only
    if (n >= DI + 2 && got_q.size() == exp_q.size() && t_done.size() == exp_q.size()) begin
      base = t_start[last_f[0] + 1] - t_done[last_f[0]];
      for (int e = 1; e < n - 1; e++) begin
        gap = t_start[last_f[e] + 1] - t_done[last_f[e]];
        if (e == DI) chk($sformatf("%s delay_gap%0d", name, e), 32'(gap - base), 32'(DC));
        else         chk($sformatf("%s entry_gap%0d", name, e), 32'(gap), 32'(base));
      end
    end
  endtask

  initial begin
    #5000000;
    $display("FAIL global_timeout: simulation did not complete, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    bit ok;
    int n;
    for (int i = 0; i < 16; i++) rom[i] = '0;

    // reset state
    repeat (3) @(negedge sys_clk);
    chk("rst busy", 32'(cfg_busy_o), 32'd0);
    chk("rst done", 32'(cfg_done_o), 32'd0);
    chk("rst index", 32'(cur_index_o), 32'd0);
    chk("rst rom_addr", 32'(rom_addr_o), 32'd0);
    chk("rst spi_start", 32'(spi_if.spi_start_o), 32'd0);
    chk("rst spi_dout", 32'(spi_if.spi_dout_o), 32'd0);
    chk("rst spi_rw", 32'(spi_if.spi_rw_o), 32'd0);
    chk("rst spi_mlb", 32'(spi_if.spi_mlb_o), 32'd1);
    reset = 1'b0;
    repeat (2) @(negedge sys_clk);

    // single entry, explicit frames
    rom[0] = 24'h0B24C0;
    run_load(1, "single");
    chk("single f0", 32'(got_q.size() > 0 ? got_q[0] : 16'hxxxx), 32'h0001);
    chk("single f3", 32'(got_q.size() > 3 ? got_q[3] : 16'hxxxx), 32'h40C0);

    // same page throughout
    rom[0] = 24'h051122; rom[1] = 24'h053344; rom[2] = 24'h055566;
    run_load(3, "same_page");

    // page change before entry 2 only
    rom[0] = 24'h00A1B1; rom[1] = 24'h00A2B2; rom[2] = 24'h01A3B3;
    run_load(3, "page_change");

    // empty table
    run_load(0, "empty");

    // randomized tables
    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < 16; i++) rom[i] = {6'd0, 2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom)};
      n = (t == 0) ? 15 : $urandom_range(1, 15);
      run_load(n, $sformatf("rand%0d", t));
    end

    // reset while the third frame is in flight, then a fresh load
    rom[0] = 24'h02C1D1; rom[1] = 24'h02C2D2; rom[2] = 24'h03C3D3;
    wait_idle("abort");
    clear_mon();
    cfg_start_i = 1'b1;
    reg_count_i = AW'(3);
    @(negedge sys_clk);
    cfg_start_i = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (got_q.size() == 3 && phase == 2) begin
        ok = 1'b1;
        break;
      end
      @(negedge sys_clk);
    end
    chk("abort reached_frame2", 32'(ok), 32'd1);
    reset = 1'b1;
    @(negedge sys_clk);
    chk("abort spi_start", 32'(spi_if.spi_start_o), 32'd0);
    chk("abort busy", 32'(cfg_busy_o), 32'd0);
    reset = 1'b0;
    run_load(3, "restart");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
